// File: rtl/csa_seq_pkg.sv
// Shared types and defaults for the sequential wide carry-skip adder.
package csa_seq_pkg;

    localparam int unsigned DEF_SLICE_W    = 16;
    localparam int unsigned DEF_NUM_SLICES = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Slice counter width; at least one bit so a single-slice build still has a counter.
    function automatic int unsigned idx_width(input int unsigned num_slices);
        return (num_slices <= 1) ? 1 : $clog2(num_slices);
    endfunction

endpackage

// File: rtl/csa_seq_wide_adder_if.sv
// Valid/ready operand and result bundle for csa_seq_wide_adder.
// With CSA_SEQ_SUB_EN defined the bundle also carries the op_sub select.
interface csa_seq_wide_adder_if #(
    parameter int unsigned W = 64
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef CSA_SEQ_SUB_EN
    logic         op_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

`ifdef CSA_SEQ_SUB_EN
    modport master (
        output in_valid, a, b, cin, op_sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, op_sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`endif

endinterface

// File: rtl/full_adder_Nbit_csa.sv
// Combinational carry-skip adder: ripple inside 4-bit blocks, block carry bypassed
// when every bit of the block propagates.
module full_adder_Nbit_csa #(
    parameter int unsigned width = 16
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic [width-1:0] sum,
    output logic             cout
);

    localparam int BLK = 4;

    // Per-bit ripple with a skip mux at each block boundary.
    always_comb begin
        logic [width:0] c;
        logic           blk_p;
        logic           blk_cin;
        c       = '0;
        c[0]    = cin;
        blk_p   = 1'b1;
        blk_cin = cin;
        sum     = '0;
        for (int i = 0; i < int'(width); i++) begin
            if (i % BLK == 0) begin
                blk_p   = 1'b1;
                blk_cin = c[i];
            end
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
            blk_p    = blk_p & (a[i] ^ b[i]);
            if ((i % BLK == BLK - 1) || (i == int'(width) - 1)) begin
                c[i+1] = blk_p ? blk_cin : c[i+1];
            end
        end
        cout = c[width];
    end

endmodule

// File: rtl/csa_seq_wide_adder.sv
// Sequential wide adder: one SLICE_W carry-skip slice reused over NUM_SLICES cycles,
// LSB slice first, inter-slice carry registered. Optional feature macro: CSA_SEQ_SUB_EN
// (adds op_sub; subtract as a + ~b + 1).
module csa_seq_wide_adder
    import csa_seq_pkg::*;
#(
    parameter int unsigned SLICE_W    = DEF_SLICE_W,
    parameter int unsigned NUM_SLICES = DEF_NUM_SLICES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    csa_seq_wide_adder_if.slave  bus
);

    localparam int unsigned W        = SLICE_W * NUM_SLICES;
    localparam int unsigned IDX_W    = idx_width(NUM_SLICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [W-1:0]       a_q, b_q, sum_q;
    logic               carry_q, cout_q, ovf_q;

    logic [W-1:0]       b_in;
    logic               carry_in;
    logic               accept, last;
    logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
    logic               slice_cout;

    // Effective B operand and initial carry as seen at capture time.
    always_comb begin
`ifdef CSA_SEQ_SUB_EN
        b_in     = bus.op_sub ? ~bus.b : bus.b;
        carry_in = bus.op_sub | bus.cin;
`else
        b_in     = bus.b;
        carry_in = bus.cin;
`endif
    end

    assign accept  = bus.in_valid && (state_q == StIdle);
    assign last    = (state_q == StRun) && (idx_q == LAST_IDX);
    assign slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
    assign slice_b = b_q[idx_q*SLICE_W +: SLICE_W];

    full_adder_Nbit_csa #(
        .width (SLICE_W)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = StRun;
            end
            StRun: begin
                if (idx_q == LAST_IDX) state_d = StDone;
            end
            StDone: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Operand capture, per-slice accumulation and final flag latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= b_in;
            carry_q <= carry_in;
            idx_q   <= '0;
        end else if (state_q == StRun) begin
            sum_q[idx_q*SLICE_W +: SLICE_W] <= slice_sum;
            carry_q <= slice_cout;
            if (last) begin
                cout_q <= slice_cout;
                ovf_q  <= (a_q[W-1] == b_q[W-1]) && (slice_sum[SLICE_W-1] != a_q[W-1]);
            end else begin
                idx_q  <= idx_q + 1'b1;
            end
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule
